// File: rtl/handshake_fifo_pkg.sv
// Shared sizing helpers for handshake_fifo: pointer width, occupancy width
// and the wrap-around pointer increment used for non-power-of-two depths.
package handshake_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit compare keeps the wrap correct when depth is not a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Generic valid/ready channel, typed by its payload. A word moves on every
// rising clock edge where valid & ready; the source holds data stable while valid & !ready.
interface handshake_if #(
    parameter type T = logic [31:0]
);
    logic valid;
    logic ready;
    T     data;

    modport receiver (input valid, input data, output ready);
    modport sender   (output valid, output data, input ready);
endinterface

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and
// one asynchronous read port; contents are never reset.
module handshake_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// First-word-fall-through FIFO between two handshake_if channels.
// Define HANDSHAKE_FIFO_COUNT_EN to expose the occupancy register on port count.
module handshake_fifo
    import handshake_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic clk,
    input  logic rst_n,
    handshake_if.receiver receiver,
    handshake_if.sender   sender
`ifdef HANDSHAKE_FIFO_COUNT_EN
    ,
    output logic [count_width(DEPTH)-1:0] count
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // ready/valid come only from the occupancy register, so neither side
    // ever sees a combinational path from the other.
    assign full           = (occupancy == CNT_W'(DEPTH));
    assign empty          = (occupancy == '0);
    assign receiver.ready = !full;
    assign sender.valid   = !empty;
    assign push           = receiver.valid && !full;
    assign pop            = sender.ready && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), $unsigned(DEPTH)));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), $unsigned(DEPTH)));
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (receiver.data),
        .raddr (rd_ptr),
        .rdata (sender.data)
    );

`ifdef HANDSHAKE_FIFO_COUNT_EN
    assign count = occupancy;
`endif

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: a queue model checked every cycle plus
// literal expectations on fill, drain, concurrent, boundary and reset scenarios.
module tb_handshake_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    handshake_if #(.T(logic [W-1:0])) up_if ();
    handshake_if #(.T(logic [W-1:0])) dn_if ();

`ifdef HANDSHAKE_FIFO_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    handshake_fifo #(
        .DATA_WIDTH (W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .receiver (up_if),
        .sender   (dn_if)
`ifdef HANDSHAKE_FIFO_COUNT_EN
        ,
        .count    (count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    bit           model_ok = 1'b0;

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a word enters when offered and fewer than DEPTH are held,
    // the head leaves when requested and something is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_ok <= 1'b1;
        end else if (model_ok) begin
            bit do_push;
            bit do_pop;
            do_push = up_if.valid && (exp_q.size() < DEPTH);
            do_pop  = dn_if.ready && (exp_q.size() > 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(up_if.data);
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("valid", {31'b0, dn_if.valid}, {31'b0, exp_q.size() != 0});
            check("ready", {31'b0, up_if.ready}, {31'b0, exp_q.size() != DEPTH});
            if (exp_q.size() != 0) check("head_data", dn_if.data, exp_q[0]);
`ifdef HANDSHAKE_FIFO_COUNT_EN
            check("count", W'(count), W'(exp_q.size()));
`endif
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [W-1:0] d, input logic sr);
        up_if.valid = rv;
        up_if.data  = d;
        dn_if.ready = sr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);

        // reset held two cycles
        step();
        check("rst_ready", {31'b0, up_if.ready}, 32'd1);
        check("rst_valid", {31'b0, dn_if.valid}, 32'd0);
        step();
        rst_n = 1'b1;

        // fill 0..3 with downstream stalled, then offer a 5th word
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(i), 1'b0);
            step();
        end
        drive(1'b1, 32'd4, 1'b0);
        check("fill_ready", {31'b0, up_if.ready}, 32'd0);
        check("fill_valid", {31'b0, dn_if.valid}, 32'd1);
        step();
        check("fill_head", dn_if.data, 32'd0);
        check("fill_depth", W'(exp_q.size()), 32'd4);

        // drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            check("drain_data", dn_if.data, W'(i));
            step();
        end
        check("drain_valid", {31'b0, dn_if.valid}, 32'd0);
        check("drain_ready", {31'b0, up_if.ready}, 32'd1);

        // pop request while empty
        drive(1'b0, '0, 1'b1);
        step();
        step();
        check("empty_pop_valid", {31'b0, dn_if.valid}, 32'd0);

        // occupancy 2, then push and pop every cycle for 10 cycles
        drive(1'b1, 32'd10, 1'b0);
        step();
        drive(1'b1, 32'd11, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(12 + i), 1'b1);
            step();
            check("conc_depth", W'(exp_q.size()), 32'd2);
        end
        check("conc_head", dn_if.data, 32'd20);

        // fill to full, then keep offering 0xFF
        drive(1'b1, 32'd22, 1'b0);
        step();
        drive(1'b1, 32'd23, 1'b0);
        step();
        drive(1'b1, 32'hFF, 1'b0);
        step();
        step();
        check("full_head", dn_if.data, 32'd20);
        check("full_ready", {31'b0, up_if.ready}, 32'd0);

        // leave 3 words, then reset mid-operation
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("pre_rst_head", dn_if.data, 32'd21);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", {31'b0, dn_if.valid}, 32'd0);
        check("mid_rst_ready", {31'b0, up_if.ready}, 32'd1);
        drive(1'b1, 32'hA5, 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        check("a5_valid", {31'b0, dn_if.valid}, 32'd1);
        check("a5_data", dn_if.data, 32'hA5);
        drive(1'b0, '0, 1'b1);
        step();
        check("a5_gone", {31'b0, dn_if.valid}, 32'd0);
        drive(1'b0, '0, 1'b0);
        step();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
